mips_pipe_core: RTL and testbench
=================================

Name: mips_pipe_core

Overview:
- 32-bit, 5-stage (IF, ID, EX, MEM, WB) in-order pipelined MIPS-subset processor.
- Single clock; self-contained, with an internal unified instruction/data word memory and a 32-entry register file.
- Benches preload these and inspect them hierarchically.
- Runs from PC 0 until a HLT instruction retires.

Parameters:
- MEM_WORDS, 1024: depth of the unified word memory `Mem`; addresses are word indices, taken modulo MEM_WORDS.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- halted  output  1  mirrors internal HALTED flag.

Behaviour:
- Internal names are fixed for hierarchical access:
  - Reg[0:31]: 32 bits each.
  - Mem[0:MEM_WORDS-1]: 32 bits each.
  - PC: 32 bits, word index.
  - HALTED, TAKEN_BRANCH: 1 bit each.
- Reset:
  - PC=RESET_PC, HALTED=0, TAKEN_BRANCH=0.
  - All pipeline registers hold NOP; halted=0.
  - Reg and Mem are NOT reset; contents are preserved, so a bench preloads them before or while reset is asserted.
- Encoding:
  - opcode[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0] sign-extended to 32 bits.
- RR ops write rd = rs op rt:
  - ADD=0, SUB=1, AND=2, OR=3.
  - SLT=4: signed compare, result 1 or 0.
  - MUL=5: optional.
- RM ops write rt = rs op imm:
  - ADDI=10, SUBI=11, SLTI=12.
- LW=8: rt = Mem[rs+imm].
- SW=9: Mem[rs+imm] = rt.
- Branches:
  - BNEQZ=13 and BEQZ=14 test rs against zero.
  - Target = (branch PC + 1) + imm.
- HLT=63.
- Any other opcode is a NOP: no register or memory write.
- Arithmetic:
  - 32-bit two's complement, wrap-around, no exceptions.
  - Writes to r0 are discarded; r0 reads as 0.
- Throughput and latency:
  - One instruction per cycle.
  - Register write happens at the end of WB, 4 cycles after IF.
- Register file is write-first: an ID read of the register being written in WB the same cycle returns the new value.
- Forwarding:
  - EX operands are forwarded from EX/MEM (ALU results) and MEM/WB (ALU or load data).
  - The younger producer wins.
  - Forwarding never applies to r0.
- Load-use:
  - No interlock.
  - An instruction that immediately follows LW and uses its destination reads the stale value; software must insert one independent instruction.
  - An instruction two slots after LW receives the loaded data via MEM/WB forwarding.
- Branches resolve in EX:
  - If taken: PC <= target on that edge, TAKEN_BRANCH pulses 1 for one cycle, and IF/ID and ID/EX are flushed to NOP.
  - Not-taken branches cost nothing.
  - No delay slot.
- HLT:
  - When HLT is in ID, fetch stops: PC holds and IF issues NOPs.
  - Older instructions complete normally.
  - When HLT reaches WB, HALTED <= 1.
  - After that, no PC, Reg, Mem or pipeline change occurs until reset.
  - If a taken branch in EX coincides with HLT in ID, the branch wins and HLT is flushed.
- SW writes Mem in MEM stage. LW reads Mem combinationally in MEM and registers the result into MEM/WB.
- IF reads Mem[PC] combinationally.
- A store to an address being fetched in the same cycle: the fetch returns the old word.
- Reset asserted mid-execution clears pipeline and flags on the next edge; in-flight writes are abandoned.

Optional Feature:
- Macro MIPS_PIPE_MUL_EN.
- Defined: opcode 5 (MUL) writes the low 32 bits of the signed product rs*rt to rd, single-cycle in EX, and is forwarded like other ALU results.
- Undefined: opcode 5 is a NOP and no multiplier is synthesized.

Test Plan:
- Reg[k]=k, with this program from Mem[0]:
  - 28010078 addi r1,r0,120
  - 0c631800 or r3,r3,r3
  - 20220000 lw r2,0(r1)
  - 0c631800 or r3,r3,r3
  - 2842002d addi r2,r2,45
  - 00222000 add r4,r1,r2
  - 0c631800 or r3,r3,r3
  - 24220001 sw r2,1(r1)
  - fc000000 hlt
  - Data Mem[120]=85, then release reset.
  - Required within 50 cycles: Mem[120]=85, Mem[121]=130, r1=120, r2=130, r4=250, halted=1.
- Back-to-back ALU forwarding: addi r1,r0,10; add r2,r1,r1; add r3,r2,r1; hlt -> r2=20, r3=30.
- Branch and flush: addi r1,r0,1; bneqz r1,+2; addi r5,r0,7; addi r6,r0,8; addi r7,r0,9; hlt -> r5 and r6 unchanged, r7=9, TAKEN_BRANCH pulses one cycle.
- Halt freeze: after halted=1, run 20 more cycles -> PC, Reg and Mem unchanged; an sw placed after hlt never writes.
- Edge values:
  - r0 write: addi r0,r0,5 -> r0 reads 0.
  - Wrap-around: add of 0x7FFFFFFF+1 gives 0x80000000.
  - SLT -1<1 gives 1.
  - SUBI 0-1 gives 0xFFFFFFFF.
- Reset mid-run: assert reset for 1 cycle after 3 instructions -> PC=0, HALTED=0, then the program re-executes to the same final state.

Source files
------------

// File: rtl/mips_pipe_core.sv
// -----------------------------------------------------------------------------
// mips_pipe_core
//   32-bit, five-stage (IF, ID, EX, MEM, WB) in-order MIPS-subset core with an
//   internal unified instruction/data word memory and a 32-entry register file.
//   Execution starts at RESET_PC and stops once a HLT instruction retires.
//
//   Ports:
//     clk    : system clock, every state update on the rising edge
//     reset  : synchronous, active-high reset (pipeline, PC and flags only)
//     halted : mirrors the internal HALTED flag
//
//   Hierarchically visible state: Reg, Mem, PC, HALTED, TAKEN_BRANCH.
//   Reg and Mem are never reset so they can be preloaded around reset.
//
//   Optional feature macro: MIPS_PIPE_MUL_EN
//     defined   : opcode 5 (MUL) writes the low 32 bits of rs*rt to rd
//     undefined : opcode 5 is a NOP and no multiplier exists
// -----------------------------------------------------------------------------
module mips_pipe_core #(
    parameter int          MEM_WORDS = 32'd1024,
    parameter logic [31:0] RESET_PC  = 32'd0
) (
    input  logic clk,
    input  logic reset,
    output logic halted
);

    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [5:0] OP_ADD   = 6'd0;
    localparam logic [5:0] OP_SUB   = 6'd1;
    localparam logic [5:0] OP_AND   = 6'd2;
    localparam logic [5:0] OP_OR    = 6'd3;
    localparam logic [5:0] OP_SLT   = 6'd4;
`ifdef MIPS_PIPE_MUL_EN
    localparam logic [5:0] OP_MUL   = 6'd5;
`endif
    localparam logic [5:0] OP_LW    = 6'd8;
    localparam logic [5:0] OP_SW    = 6'd9;
    localparam logic [5:0] OP_ADDI  = 6'd10;
    localparam logic [5:0] OP_SUBI  = 6'd11;
    localparam logic [5:0] OP_SLTI  = 6'd12;
    localparam logic [5:0] OP_BNEQZ = 6'd13;
    localparam logic [5:0] OP_BEQZ  = 6'd14;
    localparam logic [5:0] OP_HLT   = 6'd63;

    // Bubble word: opcode 7 is unassigned, so it writes nothing anywhere.
    localparam logic [31:0] NOP_IR = 32'h1C00_0000;

    // Architectural state (names fixed for hierarchical access)
    logic [31:0] Reg [0:31];
    logic [31:0] Mem [0:MEM_WORDS-1];
    logic [31:0] PC;
    logic        HALTED;
    logic        TAKEN_BRANCH;

    // Pipeline registers
    logic [31:0] if_id_ir_r, if_id_npc_r;
    logic [31:0] id_ex_ir_r, id_ex_npc_r, id_ex_a_r, id_ex_b_r, id_ex_imm_r;
    logic [31:0] ex_mem_ir_r, ex_mem_alu_r, ex_mem_b_r;
    logic [31:0] mem_wb_ir_r, mem_wb_alu_r, mem_wb_lmd_r;

    // Destination register of an instruction; 0 means "writes nothing",
    // which also makes r0 writes vanish and keeps r0 out of forwarding.
    function automatic logic [4:0] dest_of(input logic [31:0] ir);
        logic [4:0] d;
        case (ir[31:26])
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: d = ir[15:11];
`ifdef MIPS_PIPE_MUL_EN
            OP_MUL:                                d = ir[15:11];
`endif
            OP_ADDI, OP_SUBI, OP_SLTI, OP_LW:      d = ir[20:16];
            default:                               d = 5'd0;
        endcase
        return d;
    endfunction

    // True for instructions whose result is known at the end of EX.
    function automatic logic is_alu(input logic [31:0] ir);
        logic r;
        case (ir[31:26])
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: r = 1'b1;
`ifdef MIPS_PIPE_MUL_EN
            OP_MUL:                                r = 1'b1;
`endif
            OP_ADDI, OP_SUBI, OP_SLTI:             r = 1'b1;
            default:                               r = 1'b0;
        endcase
        return r;
    endfunction

    // Word address folded into the memory depth.
    function automatic logic [AW-1:0] mem_idx(input logic [31:0] addr);
        logic [31:0] wrapped;
        wrapped = addr % 32'(MEM_WORDS);
        return wrapped[AW-1:0];
    endfunction

    logic [31:0] fetch_ir_s;
    logic [4:0]  id_rs_s, id_rt_s;
    logic [31:0] id_a_s, id_b_s, id_imm_s;
    logic [4:0]  wb_dest_s, mem_dest_s;
    logic [31:0] wb_data_s;
    logic        mem_fwd_ok_s;
    logic [5:0]  ex_op_s;
    logic [4:0]  ex_rs_s, ex_rt_s;
    logic [31:0] ex_a_s, ex_b_s, ex_alu_s;
    logic        taken_s;
    logic [31:0] mem_lmd_s;
    logic        hlt_pending_s;

    assign halted = HALTED;

    assign fetch_ir_s   = Mem[mem_idx(PC)];
    assign id_rs_s      = if_id_ir_r[25:21];
    assign id_rt_s      = if_id_ir_r[20:16];
    assign id_imm_s     = {{16{if_id_ir_r[15]}}, if_id_ir_r[15:0]};
    assign wb_dest_s    = dest_of(mem_wb_ir_r);
    assign wb_data_s    = (mem_wb_ir_r[31:26] == OP_LW) ? mem_wb_lmd_r : mem_wb_alu_r;
    assign mem_dest_s   = dest_of(ex_mem_ir_r);
    assign mem_fwd_ok_s = is_alu(ex_mem_ir_r);
    assign ex_op_s      = id_ex_ir_r[31:26];
    assign ex_rs_s      = id_ex_ir_r[25:21];
    assign ex_rt_s      = id_ex_ir_r[20:16];
    assign mem_lmd_s    = Mem[mem_idx(ex_mem_alu_r)];

    // Once a HLT has been decoded anywhere past IF, fetch stays stopped.
    assign hlt_pending_s = (if_id_ir_r[31:26]  == OP_HLT) ||
                           (id_ex_ir_r[31:26]  == OP_HLT) ||
                           (ex_mem_ir_r[31:26] == OP_HLT) ||
                           (mem_wb_ir_r[31:26] == OP_HLT);

    // ID register read, write-first against the instruction in WB
    always_comb begin
        id_a_s = 32'd0;
        id_b_s = 32'd0;
        if (id_rs_s == 5'd0) begin
            id_a_s = 32'd0;
        end else if (id_rs_s == wb_dest_s) begin
            id_a_s = wb_data_s;
        end else begin
            id_a_s = Reg[id_rs_s];
        end
        if (id_rt_s == 5'd0) begin
            id_b_s = 32'd0;
        end else if (id_rt_s == wb_dest_s) begin
            id_b_s = wb_data_s;
        end else begin
            id_b_s = Reg[id_rt_s];
        end
    end

    // EX operand forwarding; EX/MEM (younger, ALU only) beats MEM/WB.
    // A load sitting in EX/MEM is deliberately not forwarded (no interlock).
    always_comb begin
        ex_a_s = id_ex_a_r;
        ex_b_s = id_ex_b_r;
        if ((ex_rs_s != 5'd0) && mem_fwd_ok_s && (mem_dest_s == ex_rs_s)) begin
            ex_a_s = ex_mem_alu_r;
        end else if ((ex_rs_s != 5'd0) && (wb_dest_s == ex_rs_s)) begin
            ex_a_s = wb_data_s;
        end else begin
            ex_a_s = id_ex_a_r;
        end
        if ((ex_rt_s != 5'd0) && mem_fwd_ok_s && (mem_dest_s == ex_rt_s)) begin
            ex_b_s = ex_mem_alu_r;
        end else if ((ex_rt_s != 5'd0) && (wb_dest_s == ex_rt_s)) begin
            ex_b_s = wb_data_s;
        end else begin
            ex_b_s = id_ex_b_r;
        end
    end

    // EX ALU: arithmetic, effective address or branch target
    always_comb begin
        ex_alu_s = 32'd0;
        case (ex_op_s)
            OP_ADD:                 ex_alu_s = ex_a_s + ex_b_s;
            OP_SUB:                 ex_alu_s = ex_a_s - ex_b_s;
            OP_AND:                 ex_alu_s = ex_a_s & ex_b_s;
            OP_OR:                  ex_alu_s = ex_a_s | ex_b_s;
            OP_SLT:                 ex_alu_s = ($signed(ex_a_s) < $signed(ex_b_s)) ? 32'd1 : 32'd0;
`ifdef MIPS_PIPE_MUL_EN
            // Low half of a product is identical for signed and unsigned.
            OP_MUL:                 ex_alu_s = ex_a_s * ex_b_s;
`endif
            OP_ADDI, OP_LW, OP_SW:  ex_alu_s = ex_a_s + id_ex_imm_r;
            OP_SUBI:                ex_alu_s = ex_a_s - id_ex_imm_r;
            OP_SLTI:                ex_alu_s = ($signed(ex_a_s) < $signed(id_ex_imm_r)) ? 32'd1 : 32'd0;
            OP_BNEQZ, OP_BEQZ:      ex_alu_s = id_ex_npc_r + id_ex_imm_r;
            default:                ex_alu_s = 32'd0;
        endcase
    end

    // Branch resolution in EX
    always_comb begin
        taken_s = 1'b0;
        case (ex_op_s)
            OP_BNEQZ: taken_s = (ex_a_s != 32'd0);
            OP_BEQZ:  taken_s = (ex_a_s == 32'd0);
            default:  taken_s = 1'b0;
        endcase
    end

    // PC, flags and pipeline registers; everything freezes once HALTED
    always_ff @(posedge clk) begin
        if (reset) begin
            PC           <= RESET_PC;
            HALTED       <= 1'b0;
            TAKEN_BRANCH <= 1'b0;
            if_id_ir_r   <= NOP_IR;
            if_id_npc_r  <= 32'd0;
            id_ex_ir_r   <= NOP_IR;
            id_ex_npc_r  <= 32'd0;
            id_ex_a_r    <= 32'd0;
            id_ex_b_r    <= 32'd0;
            id_ex_imm_r  <= 32'd0;
            ex_mem_ir_r  <= NOP_IR;
            ex_mem_alu_r <= 32'd0;
            ex_mem_b_r   <= 32'd0;
            mem_wb_ir_r  <= NOP_IR;
            mem_wb_alu_r <= 32'd0;
            mem_wb_lmd_r <= 32'd0;
        end else if (!HALTED) begin
            HALTED       <= (mem_wb_ir_r[31:26] == OP_HLT);
            TAKEN_BRANCH <= taken_s;
            if (taken_s) begin
                // Taken branch wins over a HLT in ID: both younger slots die.
                PC         <= ex_alu_s;
                if_id_ir_r <= NOP_IR;
                id_ex_ir_r <= NOP_IR;
            end else begin
                if (hlt_pending_s) begin
                    if_id_ir_r <= NOP_IR;
                end else begin
                    PC          <= PC + 32'd1;
                    if_id_ir_r  <= fetch_ir_s;
                    if_id_npc_r <= PC + 32'd1;
                end
                id_ex_ir_r  <= if_id_ir_r;
                id_ex_npc_r <= if_id_npc_r;
                id_ex_a_r   <= id_a_s;
                id_ex_b_r   <= id_b_s;
                id_ex_imm_r <= id_imm_s;
            end
            ex_mem_ir_r  <= id_ex_ir_r;
            ex_mem_alu_r <= ex_alu_s;
            ex_mem_b_r   <= ex_b_s;
            mem_wb_ir_r  <= ex_mem_ir_r;
            mem_wb_alu_r <= ex_mem_alu_r;
            mem_wb_lmd_r <= mem_lmd_s;
        end
    end

    // Register file write at the end of WB
    always_ff @(posedge clk) begin
        if (!reset && !HALTED && (wb_dest_s != 5'd0)) begin
            Reg[wb_dest_s] <= wb_data_s;
        end
    end

    // Store commit in MEM; a same-cycle fetch of that word still sees old data
    always_ff @(posedge clk) begin
        if (!reset && !HALTED && (ex_mem_ir_r[31:26] == OP_SW)) begin
            Mem[mem_idx(ex_mem_alu_r)] <= ex_mem_b_r;
        end
    end

endmodule

// File: tb/tb_mips_pipe_core.sv
// -----------------------------------------------------------------------------
// tb_mips_pipe_core
//   Directed and randomized programs for mips_pipe_core. Expected register and
//   memory contents come from an instruction-at-a-time reference interpreter
//   plus constants for the directed programs.
// -----------------------------------------------------------------------------
module tb_mips_pipe_core;

    localparam int MEMW = 1024;
    localparam logic [31:0] HLT_W = 32'hFC00_0000;

    logic clk;
    logic reset;
    logic halted;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_reg [32];
    logic [31:0] m_mem [MEMW];

    mips_pipe_core #(.MEM_WORDS(MEMW), .RESET_PC(32'd0)) dut (
        .clk    (clk),
        .reset  (reset),
        .halted (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rr(input int op, input int rd, input int rs, input int rt);
        return {6'(op), 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] ri(input int op, input int rt, input int rs, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a % 32'(MEMW));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < MEMW; i++) m_mem[i] = 32'd0;
        for (int i = 0; i < 32; i++) m_reg[i] = 32'(i);
    endtask

    // Sequential ISA interpreter: one whole instruction per step.
    task automatic model_run();
        logic [31:0] pc, ir, a, b, imm, wv;
        logic [4:0]  wd;
        bit          done;
        int          steps;
        pc = 32'd0;
        done = 1'b0;
        steps = 0;
        while (!done && steps < 2000) begin
            ir  = m_mem[widx(pc)];
            a   = (ir[25:21] == 5'd0) ? 32'd0 : m_reg[ir[25:21]];
            b   = (ir[20:16] == 5'd0) ? 32'd0 : m_reg[ir[20:16]];
            imm = {{16{ir[15]}}, ir[15:0]};
            wd  = 5'd0;
            wv  = 32'd0;
            pc  = pc + 32'd1;
            steps++;
            case (ir[31:26])
                6'd0:  begin wd = ir[15:11]; wv = a + b; end
                6'd1:  begin wd = ir[15:11]; wv = a - b; end
                6'd2:  begin wd = ir[15:11]; wv = a & b; end
                6'd3:  begin wd = ir[15:11]; wv = a | b; end
                6'd4:  begin wd = ir[15:11]; wv = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
`ifdef MIPS_PIPE_MUL_EN
                6'd5:  begin wd = ir[15:11]; wv = a * b; end
`endif
                6'd8:  begin wd = ir[20:16]; wv = m_mem[widx(a + imm)]; end
                6'd9:  m_mem[widx(a + imm)] = b;
                6'd10: begin wd = ir[20:16]; wv = a + imm; end
                6'd11: begin wd = ir[20:16]; wv = a - imm; end
                6'd12: begin wd = ir[20:16]; wv = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0; end
                6'd13: if (a != 32'd0) pc = pc + imm;
                6'd14: if (a == 32'd0) pc = pc + imm;
                6'd63: done = 1'b1;
                default: ;
            endcase
            if (wd != 5'd0) m_reg[wd] = wv;
        end
    endtask

    // Load the model image into the DUT under reset and check the reset state.
    task automatic start_run(input string tag);
        reset = 1'b1;
        for (int i = 0; i < MEMW; i++) dut.Mem[i] = m_mem[i];
        for (int i = 0; i < 32; i++) dut.Reg[i] = m_reg[i];
        @(posedge clk);
        #1;
        check({tag, "_rst_pc"}, dut.PC, 32'd0);
        check({tag, "_rst_halted_flag"}, {31'd0, dut.HALTED}, 32'd0);
        check({tag, "_rst_taken"}, {31'd0, dut.TAKEN_BRANCH}, 32'd0);
        check({tag, "_rst_halted_port"}, {31'd0, halted}, 32'd0);
        reset = 1'b0;
    endtask

    task automatic run_to_halt(input string tag, input int budget, output int taken_cnt);
        int cyc;
        cyc = 0;
        taken_cnt = 0;
        while (halted !== 1'b1 && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
            if (dut.TAKEN_BRANCH === 1'b1) taken_cnt++;
        end
        check({tag, "_halted"}, {31'd0, halted}, 32'd1);
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < 32; i++)
            check($sformatf("%s_r%0d", tag, i), dut.Reg[i], m_reg[i]);
        for (int i = 0; i < 256; i++)
            check($sformatf("%s_mem%0d", tag, i), dut.Mem[i], m_mem[i]);
    endtask

    task automatic gen_random();
        int idx, kind, lim;
        clear_model();
        for (int r = 1; r < 8; r++) m_reg[r] = $urandom;
        for (int d = 200; d < 216; d++) m_mem[d] = $urandom;
        idx = 0;
        while (idx < 24) begin
            kind = int'($urandom_range(0, 10));
            if (kind <= 5) begin
                m_mem[idx] = rr(int'($urandom_range(0, 5)), int'($urandom_range(0, 7)),
                                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
                idx++;
            end else if (kind <= 7) begin
                m_mem[idx] = ri(int'($urandom_range(10, 12)), int'($urandom_range(0, 7)),
                                int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)));
                idx++;
            end else if (kind == 8 && idx <= 22) begin
                // Load followed by an independent filler to respect load-use.
                m_mem[idx]     = ri(8, int'($urandom_range(0, 7)), 0, int'($urandom_range(200, 215)));
                m_mem[idx + 1] = rr(3, 0, 0, 0);
                idx += 2;
            end else if (kind == 9) begin
                m_mem[idx] = ri(9, int'($urandom_range(0, 7)), 0, int'($urandom_range(200, 215)));
                idx++;
            end else begin
                lim = 24 - idx - 1;
                if (lim > 2) lim = 2;
                m_mem[idx] = ri(int'($urandom_range(13, 14)), 0, int'($urandom_range(0, 7)),
                                int'($urandom_range(0, lim)));
                idx++;
            end
        end
        m_mem[24] = HLT_W;
    endtask

    initial begin
        int tcnt;
        logic [31:0] exp_r8;
        reset = 1'b1;

        // Reference program with load, forwarding and store
        clear_model();
        m_mem[0] = 32'h28010078;
        m_mem[1] = 32'h0c631800;
        m_mem[2] = 32'h20220000;
        m_mem[3] = 32'h0c631800;
        m_mem[4] = 32'h2842002d;
        m_mem[5] = 32'h00222000;
        m_mem[6] = 32'h0c631800;
        m_mem[7] = 32'h24220001;
        m_mem[8] = 32'hfc000000;
        m_mem[120] = 32'd85;
        start_run("plan");
        model_run();
        run_to_halt("plan", 50, tcnt);
        check("plan_mem120", dut.Mem[120], 32'd85);
        check("plan_mem121", dut.Mem[121], 32'd130);
        check("plan_r1", dut.Reg[1], 32'd120);
        check("plan_r2", dut.Reg[2], 32'd130);
        check("plan_r4", dut.Reg[4], 32'd250);
        check("plan_pc", dut.PC, 32'd9);
        compare_all("plan");

        // Back-to-back forwarding, then halt freeze with a store after HLT
        clear_model();
        m_mem[0] = ri(10, 1, 0, 10);
        m_mem[1] = rr(0, 2, 1, 1);
        m_mem[2] = rr(0, 3, 2, 1);
        m_mem[3] = HLT_W;
        m_mem[4] = ri(9, 1, 0, 200);
        start_run("fwd");
        model_run();
        run_to_halt("fwd", 40, tcnt);
        check("fwd_r2", dut.Reg[2], 32'd20);
        check("fwd_r3", dut.Reg[3], 32'd30);
        repeat (20) @(posedge clk);
        #1;
        check("freeze_pc", dut.PC, 32'd4);
        check("freeze_halted", {31'd0, halted}, 32'd1);
        check("freeze_mem200", dut.Mem[200], 32'd0);
        compare_all("freeze");

        // Reset for one cycle after three instructions, then rerun
        start_run("mid");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_pc", dut.PC, 32'd0);
        check("mid_halted_flag", {31'd0, dut.HALTED}, 32'd0);
        reset = 1'b0;
        run_to_halt("mid", 40, tcnt);
        check("mid_r2", dut.Reg[2], 32'd20);
        check("mid_r3", dut.Reg[3], 32'd30);
        compare_all("mid");

        // Taken branch flushes two slots
        clear_model();
        m_mem[0] = ri(10, 1, 0, 1);
        m_mem[1] = ri(13, 0, 1, 2);
        m_mem[2] = ri(10, 5, 0, 7);
        m_mem[3] = ri(10, 6, 0, 8);
        m_mem[4] = ri(10, 7, 0, 9);
        m_mem[5] = HLT_W;
        start_run("br");
        model_run();
        run_to_halt("br", 40, tcnt);
        check("br_r5", dut.Reg[5], 32'd5);
        check("br_r6", dut.Reg[6], 32'd6);
        check("br_r7", dut.Reg[7], 32'd9);
        check("br_taken_cycles", 32'(tcnt), 32'd1);
        check("br_pc", dut.PC, 32'd6);
        compare_all("br");

        // Edge values
        clear_model();
        m_reg[1] = 32'h7FFF_FFFF;
        m_reg[2] = 32'd1;
        m_reg[5] = 32'hFFFF_FFFF;
        m_reg[6] = 32'd1;
        m_reg[9] = 32'hFFFF_FFFD;
        m_reg[10] = 32'd5;
        m_mem[0] = ri(10, 0, 0, 5);
        m_mem[1] = rr(0, 3, 1, 2);
        m_mem[2] = rr(4, 4, 5, 6);
        m_mem[3] = ri(11, 7, 0, 1);
        m_mem[4] = rr(5, 8, 9, 10);
        m_mem[5] = rr(40, 11, 1, 2);
        m_mem[6] = ri(12, 12, 5, 0);
        m_mem[7] = HLT_W;
        start_run("edge");
        model_run();
        run_to_halt("edge", 40, tcnt);
`ifdef MIPS_PIPE_MUL_EN
        exp_r8 = 32'hFFFF_FFF1;
`else
        exp_r8 = 32'd8;
`endif
        check("edge_r0", dut.Reg[0], 32'd0);
        check("edge_wrap", dut.Reg[3], 32'h8000_0000);
        check("edge_slt", dut.Reg[4], 32'd1);
        check("edge_subi", dut.Reg[7], 32'hFFFF_FFFF);
        check("edge_mul", dut.Reg[8], exp_r8);
        check("edge_badop", dut.Reg[11], 32'd11);
        check("edge_slti", dut.Reg[12], 32'd1);
        compare_all("edge");

        // Randomized programs against the interpreter
        for (int t = 0; t < 6; t++) begin
            gen_random();
            start_run($sformatf("rnd%0d", t));
            model_run();
            run_to_halt($sformatf("rnd%0d", t), 120, tcnt);
            compare_all($sformatf("rnd%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
